bp_be_dep_tracker: RTL and testbench
====================================

Name: bp_be_dep_tracker

Overview:
- Back-end pipe dependency tracker, directly upstream of the hazard detector.
- Records every dispatched instruction's destination register, write-file flags and functional-unit class.
- Shifts that record down the execution pipe one stage per cycle.
- Publishes per-stage "result not yet forwardable" status, which the detector compares against issuing source registers to raise data hazards.

Parameters:
- depth_p, 5: execution stages tracked (stage 0 = first execute stage).
- reg_addr_width_p, 5: register specifier width.
- commit_stage_p, 2: first stage whose entry is immune to poison_ex_i; legal range 1..depth_p-1.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- dispatch_v_i  in  1  instruction enters stage 0 this cycle.
- dispatch_rd_addr_i  in  reg_addr_width_p  destination register.
- dispatch_irf_w_v_i  in  1  writes integer register file.
- dispatch_frf_w_v_i  in  1  writes FP register file.
- dispatch_fu_class_i  in  2  0=ALU, 1=MUL, 2=MEM, 3=FP.
- poison_ex_i  in  1  kill entries in stages below commit_stage_p.
- flush_i  in  1  kill all entries and the incoming dispatch (roll).
- stage_v_o  out  depth_p  per-stage valid.
- stage_rd_addr_o  out  depth_p*reg_addr_width_p  per-stage rd; stage s at bits [s*W +: W].
- stage_irf_pend_o  out  depth_p  integer result pending at stage s.
- stage_frf_pend_o  out  depth_p  FP result pending at stage s.
- commit_v_o  out  1  entry leaving the last stage this cycle.
- commit_rd_addr_o  out  reg_addr_width_p  rd of the leaving entry.
- commit_irf_w_v_o  out  1  integer write flag of the leaving entry.
- commit_frf_w_v_o  out  1  FP write flag of the leaving entry.
- inflight_cnt_o  out  clog2(depth_p+1)  count of valid stages.

Behaviour:
- Reset (asynchronous, while reset_n_i=0): all stage valids, stored fields and inflight_cnt_o are 0. Consequently every output is 0.
- Per-stage registers: valid, rd, irf_w, frf_w, fu_class. No stall; every entry advances every cycle.
- Stage 0 next value: valid = dispatch_v_i & ~flush_i; fields are taken from the dispatch_* inputs.
- Stage s>0 next value: takes stage s-1. Valid is cleared if flush_i, or if poison_ex_i and (s-1) < commit_stage_p.
- Ordering: poison applies to the current contents; a dispatch in the same cycle as poison_ex_i is still accepted. flush_i dominates poison_ex_i and dispatch.
- irf_w is stored as dispatch_irf_w_v_i & (rd != 0); writes to x0 are never tracked.
- Latencies (stages in which the result is pending), by class:
  - int_lat: ALU=1, MUL=2, MEM=2, FP=0.
  - fp_lat: ALU=0, MUL=0, MEM=2, FP=3.
- Pending outputs (combinational from registered state):
  - stage_irf_pend_o[s] = v & irf_w & (s < int_lat).
  - stage_frf_pend_o[s] = v & frf_w & (s < fp_lat).
- commit_* outputs are combinational from stage depth_p-1. Its valid is gated by flush_i, and by poison_ex_i only if depth_p-1 < commit_stage_p.
- inflight_cnt_o is registered and equals the popcount of next-state valids. It never exceeds depth_p, with no wrap.
- Reset deasserted mid-stream: the pipe restarts empty. Deassertion is synchronised externally.

Optional Feature:
- Macro BP_BE_DEP_ALU_BYPASS_EN.
- Defined: ALU int_lat=0, so ALU results are never reported pending (full ex-stage forwarding). All other classes are unchanged.
- Undefined: ALU int_lat=1 as above.

Decomposition:
- Shared package bp_be_dep_pkg holds:
  - the fu_class enum (ALU/MUL/MEM/FP);
  - the int_lat/fp_lat constant lookup functions;
  - a packed dep_entry_s struct {v, rd, irf_w, frf_w, fu_class}.
- One natural sub-module, bp_be_dep_stage: a single entry register with kill inputs and a pending-bit computation. It is instantiated depth_p times in a generate loop.

Test Plan:
- Reset then idle: after reset_n_i=0→1, all outputs are 0 for 10 cycles.
- Dispatch ALU with rd=7 and irf_w=1: the next cycle shows stage_v_o=00001 and stage_irf_pend_o=00001. One cycle later stage_irf_pend_o=00000 with stage_v_o=00010. Commit of rd=7 appears at stage 4. With BP_BE_DEP_ALU_BYPASS_EN, stage_irf_pend_o stays 0 throughout.
- Dispatch FP with rd=3 and frf_w=1: stage_frf_pend_o is 1 at stages 0, 1 and 2 and 0 at stages 3 and 4. stage_irf_pend_o stays 0.
- Dispatch ALU with rd=0 and irf_w=1: stage_v_o propagates, but stage_irf_pend_o stays 0 and commit_irf_w_v_o=0.
- Back-to-back dispatch of 5 MUL ops, then poison_ex_i pulsed with a 6th dispatch in the same cycle: the entries in stages 0 and 1 vanish, the entries in stages 2 to 4 survive and shift, and the new op enters stage 0. inflight_cnt_o goes from 5 to 3, not 4, because the stage-4 entry leaves the pipe that same cycle.
- Full pipe with flush_i and dispatch_v_i both asserted: the next cycle stage_v_o=0 and inflight_cnt_o=0, with commit_v_o=0 during the flush cycle.

Source files
------------

// File: rtl/bp_be_dep_pkg.sv
// Shared types and latency lookups for the back-end dependency tracker.
// Build option: BP_BE_DEP_ALU_BYPASS_EN removes ALU integer pending time (full ex forwarding).
package bp_be_dep_pkg;

    // Stored rd field is sized for the widest register specifier the tracker supports.
    localparam int dep_rd_width_gp = 8;

    typedef enum logic [1:0] {
        e_fu_alu = 2'd0,
        e_fu_mul = 2'd1,
        e_fu_mem = 2'd2,
        e_fu_fp  = 2'd3
    } fu_class_e;

    typedef struct packed {
        logic                       v;
        logic [dep_rd_width_gp-1:0] rd;
        logic                       irf_w;
        logic                       frf_w;
        fu_class_e                  fu_class;
    } dep_entry_s;

    function automatic int int_lat(input fu_class_e fu_class);
        int lat;
        lat = 0;
        case (fu_class)
`ifdef BP_BE_DEP_ALU_BYPASS_EN
            e_fu_alu: lat = 0;
`else
            e_fu_alu: lat = 1;
`endif
            e_fu_mul: lat = 2;
            e_fu_mem: lat = 2;
            e_fu_fp:  lat = 0;
            default:  lat = 0;
        endcase
        return lat;
    endfunction

    function automatic int fp_lat(input fu_class_e fu_class);
        int lat;
        lat = 0;
        case (fu_class)
            e_fu_alu: lat = 0;
            e_fu_mul: lat = 0;
            e_fu_mem: lat = 2;
            e_fu_fp:  lat = 3;
            default:  lat = 0;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/bp_be_dep_stage.sv
// One execution-stage slot of the dependency tracker: entry register with kill
// and the per-stage "result not yet forwardable" bits.
module bp_be_dep_stage
    import bp_be_dep_pkg::*;
#(
    parameter int stage_idx_p = 0
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  dep_entry_s entry_i,
    input  logic       kill_i,
    output logic       next_v_o,
    output dep_entry_s entry_o,
    output logic       irf_pend_o,
    output logic       frf_pend_o
);

    dep_entry_s entry_n;

    assign next_v_o = entry_i.v & ~kill_i;

    always_comb begin
        entry_n   = entry_i;
        entry_n.v = next_v_o;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            entry_o <= '0;
        end else begin
            entry_o <= entry_n;
        end
    end

    // A result is pending while the entry sits in a stage earlier than its class latency.
    assign irf_pend_o = entry_o.v & entry_o.irf_w & (stage_idx_p < int_lat(entry_o.fu_class));
    assign frf_pend_o = entry_o.v & entry_o.frf_w & (stage_idx_p < fp_lat(entry_o.fu_class));

endmodule

// File: rtl/bp_be_dep_tracker.sv
// Back-end dependency tracker: shifts dispatched destination records down the
// execution pipe and publishes per-stage pending status for hazard detection.
// Build option: BP_BE_DEP_ALU_BYPASS_EN (see bp_be_dep_pkg).
module bp_be_dep_tracker
    import bp_be_dep_pkg::*;
#(
    parameter int depth_p          = 5,
    parameter int reg_addr_width_p = 5,
    parameter int commit_stage_p   = 2,
    localparam int cnt_width_lp    = $clog2(depth_p + 1)
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic                                 dispatch_v_i,
    input  logic [reg_addr_width_p-1:0]          dispatch_rd_addr_i,
    input  logic                                 dispatch_irf_w_v_i,
    input  logic                                 dispatch_frf_w_v_i,
    input  logic [1:0]                           dispatch_fu_class_i,
    input  logic                                 poison_ex_i,
    input  logic                                 flush_i,
    output logic [depth_p-1:0]                   stage_v_o,
    output logic [depth_p*reg_addr_width_p-1:0]  stage_rd_addr_o,
    output logic [depth_p-1:0]                   stage_irf_pend_o,
    output logic [depth_p-1:0]                   stage_frf_pend_o,
    output logic                                 commit_v_o,
    output logic [reg_addr_width_p-1:0]          commit_rd_addr_o,
    output logic                                 commit_irf_w_v_o,
    output logic                                 commit_frf_w_v_o,
    output logic [cnt_width_lp-1:0]              inflight_cnt_o
);

    typedef logic [cnt_width_lp-1:0] cnt_t;

    dep_entry_s           dispatch_entry;
    dep_entry_s           stage_in [depth_p];
    dep_entry_s           stage_q  [depth_p];
    logic [depth_p-1:0]   stage_kill;
    logic [depth_p-1:0]   next_v;
    logic                 commit_kill;
    cnt_t                 cnt_n;

    // x0 writes are dropped here so no downstream stage ever reports them pending.
    always_comb begin
        dispatch_entry          = '0;
        dispatch_entry.v        = dispatch_v_i;
        dispatch_entry.rd       = dep_rd_width_gp'(dispatch_rd_addr_i);
        dispatch_entry.irf_w    = dispatch_irf_w_v_i & (dispatch_rd_addr_i != '0);
        dispatch_entry.frf_w    = dispatch_frf_w_v_i;
        dispatch_entry.fu_class = fu_class_e'(dispatch_fu_class_i);
    end

    for (genvar s = 0; s < depth_p; s++) begin : g_stage
        if (s == 0) begin : g_head
            assign stage_in[s]   = dispatch_entry;
            assign stage_kill[s] = flush_i;
        end else begin : g_body
            assign stage_in[s]   = stage_q[s-1];
            assign stage_kill[s] = flush_i | (poison_ex_i & ((s - 1) < commit_stage_p));
        end

        bp_be_dep_stage #(
            .stage_idx_p (s)
        ) u_stage (
            .clk_i      (clk_i),
            .reset_n_i  (reset_n_i),
            .entry_i    (stage_in[s]),
            .kill_i     (stage_kill[s]),
            .next_v_o   (next_v[s]),
            .entry_o    (stage_q[s]),
            .irf_pend_o (stage_irf_pend_o[s]),
            .frf_pend_o (stage_frf_pend_o[s])
        );

        assign stage_v_o[s] = stage_q[s].v;
        assign stage_rd_addr_o[s*reg_addr_width_p +: reg_addr_width_p] =
            stage_q[s].rd[reg_addr_width_p-1:0];
    end

    // The leaving entry obeys the same kill rule a hypothetical stage depth_p would.
    assign commit_kill      = flush_i | (poison_ex_i & ((depth_p - 1) < commit_stage_p));
    assign commit_v_o       = stage_q[depth_p-1].v & ~commit_kill;
    assign commit_rd_addr_o = stage_q[depth_p-1].rd[reg_addr_width_p-1:0];
    assign commit_irf_w_v_o = stage_q[depth_p-1].irf_w;
    assign commit_frf_w_v_o = stage_q[depth_p-1].frf_w;

    always_comb begin
        cnt_n = '0;
        for (int s = 0; s < depth_p; s++) begin
            cnt_n = cnt_n + cnt_t'(next_v[s]);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            inflight_cnt_o <= '0;
        end else begin
            inflight_cnt_o <= cnt_n;
        end
    end

endmodule

// File: tb/tb_bp_be_dep_tracker.sv
// Directed self-checking bench for bp_be_dep_tracker (depth 5, commit stage 2).
module tb_bp_be_dep_tracker;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        dispatch_v_i;
    logic [4:0]  dispatch_rd_addr_i;
    logic        dispatch_irf_w_v_i;
    logic        dispatch_frf_w_v_i;
    logic [1:0]  dispatch_fu_class_i;
    logic        poison_ex_i;
    logic        flush_i;
    logic [4:0]  stage_v_o;
    logic [24:0] stage_rd_addr_o;
    logic [4:0]  stage_irf_pend_o;
    logic [4:0]  stage_frf_pend_o;
    logic        commit_v_o;
    logic [4:0]  commit_rd_addr_o;
    logic        commit_irf_w_v_o;
    logic        commit_frf_w_v_o;
    logic [2:0]  inflight_cnt_o;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef BP_BE_DEP_ALU_BYPASS_EN
    localparam logic [4:0] alu_pend0_exp = 5'b00000;
`else
    localparam logic [4:0] alu_pend0_exp = 5'b00001;
`endif

    bp_be_dep_tracker dut (
        .clk_i               (clk_i),
        .reset_n_i           (reset_n_i),
        .dispatch_v_i        (dispatch_v_i),
        .dispatch_rd_addr_i  (dispatch_rd_addr_i),
        .dispatch_irf_w_v_i  (dispatch_irf_w_v_i),
        .dispatch_frf_w_v_i  (dispatch_frf_w_v_i),
        .dispatch_fu_class_i (dispatch_fu_class_i),
        .poison_ex_i         (poison_ex_i),
        .flush_i             (flush_i),
        .stage_v_o           (stage_v_o),
        .stage_rd_addr_o     (stage_rd_addr_o),
        .stage_irf_pend_o    (stage_irf_pend_o),
        .stage_frf_pend_o    (stage_frf_pend_o),
        .commit_v_o          (commit_v_o),
        .commit_rd_addr_o    (commit_rd_addr_o),
        .commit_irf_w_v_o    (commit_irf_w_v_o),
        .commit_frf_w_v_o    (commit_frf_w_v_o),
        .inflight_cnt_o      (inflight_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic irf,
                         input logic frf, input logic [1:0] fu);
        dispatch_v_i        = v;
        dispatch_rd_addr_i  = rd;
        dispatch_irf_w_v_i  = irf;
        dispatch_frf_w_v_i  = frf;
        dispatch_fu_class_i = fu;
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({stage_v_o, stage_irf_pend_o, stage_frf_pend_o, commit_v_o,
                    commit_irf_w_v_o, commit_frf_w_v_o, inflight_cnt_o})
             | 32'(|stage_rd_addr_o) | 32'(|commit_rd_addr_o);
    endfunction

    initial begin
        reset_n_i   = 1'b0;
        poison_ex_i = 1'b0;
        flush_i     = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 1'b0, 2'd0);
        repeat (3) tick();
        check("reset_outs", all_outs(), 32'd0);
        reset_n_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_outs", all_outs(), 32'd0);
        end

        // ALU rd=7
        drive(1'b1, 5'd7, 1'b1, 1'b0, 2'd0);
        tick();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 2'd0);
        check("alu_v0", 32'(stage_v_o), 32'h01);
        check("alu_pend0", 32'(stage_irf_pend_o), 32'(alu_pend0_exp));
        check("alu_rd0", 32'(stage_rd_addr_o[4:0]), 32'd7);
        tick();
        check("alu_v1", 32'(stage_v_o), 32'h02);
        check("alu_pend1", 32'(stage_irf_pend_o), 32'h00);
        repeat (3) tick();
        check("alu_v4", 32'(stage_v_o), 32'h10);
        check("alu_cv", 32'(commit_v_o), 32'd1);
        check("alu_crd", 32'(commit_rd_addr_o), 32'd7);
        check("alu_cirf", 32'(commit_irf_w_v_o), 32'd1);
        check("alu_cnt", 32'(inflight_cnt_o), 32'd1);
        tick();
        check("alu_drain", 32'({stage_v_o, commit_v_o, inflight_cnt_o}), 32'd0);

        // FP rd=3: frf pending in stages 0..2
        drive(1'b1, 5'd3, 1'b0, 1'b1, 2'd3);
        tick();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 2'd0);
        for (int s = 0; s < 5; s++) begin
            check("fp_frf_pend", 32'(stage_frf_pend_o), (s < 3) ? (32'd1 << s) : 32'd0);
            check("fp_irf_pend", 32'(stage_irf_pend_o), 32'd0);
            check("fp_v", 32'(stage_v_o), 32'd1 << s);
            if (s < 4) tick();
        end
        check("fp_cfrf", 32'({commit_v_o, commit_frf_w_v_o, commit_irf_w_v_o}), 32'b110);
        tick();

        // ALU writing x0: tracked as valid, never pending
        drive(1'b1, 5'd0, 1'b1, 1'b0, 2'd0);
        tick();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 2'd0);
        check("x0_v0", 32'(stage_v_o), 32'h01);
        check("x0_pend0", 32'(stage_irf_pend_o), 32'd0);
        repeat (4) tick();
        check("x0_cv", 32'(commit_v_o), 32'd1);
        check("x0_cirf", 32'(commit_irf_w_v_o), 32'd0);
        tick();

        // Five MUL ops rd=1..5 then poison with a sixth dispatch
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 5'(i), 1'b1, 1'b0, 2'd1);
            tick();
        end
        check("mul_full_v", 32'(stage_v_o), 32'h1F);
        check("mul_full_cnt", 32'(inflight_cnt_o), 32'd5);
        check("mul_pend", 32'(stage_irf_pend_o), 32'h03);
        check("mul_rd4", 32'(stage_rd_addr_o[24:20]), 32'd1);
        drive(1'b1, 5'd6, 1'b1, 1'b0, 2'd1);
        poison_ex_i = 1'b1;
        #1;
        check("poison_cv", 32'(commit_v_o), 32'd1);
        check("poison_crd", 32'(commit_rd_addr_o), 32'd1);
        tick();
        poison_ex_i = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 1'b0, 2'd0);
        check("poison_v", 32'(stage_v_o), 32'b11001);
        check("poison_cnt", 32'(inflight_cnt_o), 32'd3);
        check("poison_rd0", 32'(stage_rd_addr_o[4:0]), 32'd6);
        check("poison_rd3", 32'(stage_rd_addr_o[19:15]), 32'd3);
        check("poison_rd4", 32'(stage_rd_addr_o[24:20]), 32'd2);

        // Refill, then flush with a concurrent dispatch
        for (int i = 10; i < 15; i++) begin
            drive(1'b1, 5'(i), 1'b1, 1'b0, 2'd0);
            tick();
        end
        check("refill_v", 32'(stage_v_o), 32'h1F);
        flush_i = 1'b1;
        drive(1'b1, 5'd20, 1'b1, 1'b0, 2'd0);
        #1;
        check("flush_cv", 32'(commit_v_o), 32'd0);
        tick();
        flush_i = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 1'b0, 2'd0);
        check("flush_v", 32'(stage_v_o), 32'd0);
        check("flush_cnt", 32'(inflight_cnt_o), 32'd0);

        // Asynchronous reset mid-stream
        drive(1'b1, 5'd9, 1'b1, 1'b1, 2'd2);
        tick();
        tick();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 2'd0);
        check("mem_pend", 32'({stage_irf_pend_o, stage_frf_pend_o}), 32'h063);
        #2;
        reset_n_i = 1'b0;
        #1;
        check("async_reset", all_outs(), 32'd0);
        tick();
        reset_n_i = 1'b1;
        tick();
        check("restart_empty", all_outs(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
